// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// State encoding, header width and default memory depth.
package imem_loader_pkg;

    localparam int unsigned HDR_W         = 16;
    localparam int unsigned DEFAULT_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_e;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word.
// word_ready fires combinationally alongside the lane-3 byte strobe.
module imem_loader_byte_word_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_strobe,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;

    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        if (i_clear) begin
            lane_d = 2'd0;
            asm_d  = '0;
        end else if (i_strobe) begin
            lane_d = lane_q + 2'd1;
            unique case (lane_q)
                2'd0:    asm_d[7:0]   = i_byte;
                2'd1:    asm_d[15:8]  = i_byte;
                2'd2:    asm_d[23:16] = i_byte;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lane_q <= 2'd0;
            asm_q  <= '0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

    // Top byte is passed straight through so the word is complete on the lane-3 edge.
    assign o_word       = {i_byte, asm_q};
    assign o_word_ready = i_strobe && !i_clear && (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word-count header, streams little-endian words
// into instruction memory and holds the core in reset until the image is in.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_cpu_rst_n,
    output logic [15:0]       o_word_count
);

    state_e             state_q, state_d;
    logic [HDR_W-1:0]   len_q, len_d;
    logic [15:0]        count_q, count_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               pack_strobe;
    logic               pack_clear;
    logic [31:0]        pack_word;
    logic               pack_ready;
    logic [HDR_W-1:0]   hdr_full;
    logic [15:0]        count_inc;

    assign pack_strobe = (state_q == DATA) && i_rx_valid;
    assign pack_clear  = (state_q == LEN_HI) && i_rx_valid;
    assign hdr_full    = {i_rx_data, len_q[7:0]};
    assign count_inc   = count_q + 16'd1;

    imem_loader_byte_word_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_byte       (i_rx_data),
        .i_strobe     (pack_strobe),
        .i_clear      (pack_clear),
        .o_word       (pack_word),
        .o_word_ready (pack_ready)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        o_rx_ready  = 1'b0;
        o_we        = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_error     = 1'b0;
        o_cpu_rst_n = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LEN_LO;
                    count_d = '0;
                end
            end
            LEN_LO: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_rx_valid) begin
                    len_d[7:0] = i_rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_rx_valid) begin
                    len_d = hdr_full;
                    if (hdr_full == '0) begin
                        state_d = DONE;
                    end else if (32'(hdr_full) > DEPTH) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
                if (pack_ready) begin
                    // Address and data are latched here so WRITE presents them registered.
                    waddr_d = ADDR_W'({count_q, 2'b00});
                    wdata_d = pack_word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                o_we    = 1'b1;
                o_busy  = 1'b1;
                count_d = count_inc;
                state_d = (count_inc == len_q) ? DONE : DATA;
            end
            DONE: begin
                o_done      = 1'b1;
                o_cpu_rst_n = 1'b1;
                if (i_start) begin
                    state_d = LEN_LO;
                    count_d = '0;
                end
            end
            ERROR: begin
                o_error = 1'b1;
                if (i_start) begin
                    state_d = LEN_LO;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_waddr      = waddr_q;
    assign o_wdata      = wdata_q;
    assign o_word_count = count_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 32-bit word-addressed instruction memory; counterpart to its read-only fetch port.
- Accepts a byte stream from a UART RX or debug link through a valid/ready interface.
- Parses a 16-bit word-count header, assembles little-endian 32-bit words and drives a single-cycle write strobe.
- Holds the core in reset until the image has fully loaded.

Parameters:
- DEPTH, 256, number of 32-bit words in the instruction memory. Maximum legal word count.
- ADDR_W, 32, width of the byte address driven on o_waddr.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- i_rx_data  input  8  incoming byte.
- i_rx_valid  input  1  i_rx_data is valid.
- o_rx_ready  output  1  loader accepts a byte this cycle. A byte transfers when i_rx_valid && o_rx_ready.
- o_we  output  1  instruction-memory write strobe, one cycle per word.
- o_waddr  output  ADDR_W  byte address of the write; always word-aligned (word_index << 2).
- o_wdata  output  32  assembled instruction word.
- o_busy  output  1  load in progress (states LEN_LO, LEN_HI, DATA, WRITE).
- o_done  output  1  image loaded. Held until the next i_start or reset.
- o_error  output  1  header word count exceeded DEPTH. Held until the next i_start or reset.
- o_cpu_rst_n  output  1  core reset release. 1 only in DONE.
- o_word_count  output  16  number of words written so far in the current load.

Behaviour:
- Reset (async assert, sync deassert on i_clk):
  - state=IDLE.
  - o_rx_ready=0, o_we=0, o_waddr=0, o_wdata=0.
  - o_busy=0, o_done=0, o_error=0, o_cpu_rst_n=0, o_word_count=0.
  - Byte lane counter=0, header register=0.
- IDLE:
  - o_rx_ready=0.
  - i_start -> LEN_LO, clear o_word_count.
- LEN_LO:
  - o_rx_ready=1.
  - On transfer: len[7:0]=byte -> LEN_HI.
- LEN_HI:
  - o_rx_ready=1.
  - On transfer: len[15:8]=byte. Decide on the full 16-bit value:
    - len==0 -> DONE.
    - len>DEPTH -> ERROR.
    - otherwise -> DATA with lane=0.
- DATA:
  - o_rx_ready=1.
  - A byte accepted on lane k goes to bits [8k+7:8k] (little-endian). lane increments.
  - The transfer on lane 3 -> WRITE; lane wraps to 0.
- WRITE (exactly one cycle):
  - o_rx_ready=0, o_we=1, o_waddr=o_word_count<<2, o_wdata=assembled word.
  - On exit, o_word_count increments.
  - If the incremented count equals len -> DONE, else -> DATA.
- Write latency: o_we rises in the cycle after the edge that accepted lane 3. Minimum cost is 5 cycles per word.
- DONE:
  - o_done=1, o_cpu_rst_n=1, o_rx_ready=0.
  - i_start -> LEN_LO, with o_done=0 and o_cpu_rst_n=0 in the next cycle (reload).
- ERROR:
  - o_error=1, o_cpu_rst_n=0, o_rx_ready=0.
  - Only i_start (-> LEN_LO, clears o_error) or reset exits.
- o_we is 0 in every state except WRITE. o_waddr and o_wdata hold their last values otherwise.
- i_start while o_busy=1 is ignored; the load continues unaffected.
- Gaps in i_rx_valid stall the FSM indefinitely with no state change. There is no timeout.
- i_rx_data is sampled only on a transfer. Bytes offered while o_rx_ready=0 are not consumed.
- Reset mid-load:
  - Immediate return to reset values; a partially assembled word is discarded.
  - Words already written remain in memory. The core stays in reset.
- Extra bytes after the last word are not consumed (o_rx_ready=0 in DONE).
- The header-to-DONE decision for len==DEPTH is legal: it writes addresses 0..(DEPTH-1)*4.

Decomposition:
- Shared package imem_loader_pkg holds:
  - state encoding localparams IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR (3-bit);
  - HDR_W=16;
  - default DEPTH=256.
- One natural sub-module: byte_word_packer.
  - Lane counter plus a 32-bit little-endian assembly register.
  - Inputs: byte, strobe, clear. Outputs: word, word_ready on the lane-3 strobe.
  - The FSM, header parsing and write/count logic stay in imem_loader.

Test Plan:
- Normal load: i_start, then stream 02 00 13 00 00 00 93 00 10 00 with valid held high:
  - o_we pulses twice: addr 0x0 / data 0x00000013, then addr 0x4 / data 0x00100093.
  - o_done=1 and o_cpu_rst_n=1 in the cycle after the second WRITE; o_word_count=2.
- Zero length: i_start, then 00 00 -> DONE in the cycle after the second byte with no o_we, o_done=1, o_word_count=0.
- Oversize: i_start, then 01 01 (257) -> o_error=1, o_rx_ready=0, o_cpu_rst_n=0, no writes. A subsequent i_start clears o_error and returns to LEN_LO.
- Backpressure and gaps: 1-word load with i_rx_valid toggling 1,0,0,1,... -> identical o_wdata=0xDEADBEEF from bytes EF BE AD DE, and exactly one o_we.
- i_start pulsed during DATA -> ignored; the load completes normally with the correct word count.
- Reset mid-load: assert i_rst_n=0 after 2 of 4 data bytes -> all outputs return to reset values asynchronously. A fresh 1-word load afterwards writes addr 0x0 with the new word only.
